// File: rtl/branch_resolve_unit.sv
// Carries decode-stage branch predictions to MEM, resolves them against the actual
// outcome, and issues a registered flush plus corrected fetch address on a mispredict.
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_id_branch,
  input  logic [31:0]      i_id_pc,
  input  logic             i_id_prediction,
  input  logic [29:0]      i_id_target,
  input  logic             i_mem_branch,
  input  logic             i_mem_taken,
  input  logic             i_cnt_clr,
  output logic             o_flush,
  output logic [31:0]      o_recover_pc,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic             o_orphan_err
);

  logic             r_ex_valid, r_ex_pred;
  logic [31:0]      r_ex_tgt, r_ex_fall;
  logic             r_mem_valid, r_mem_pred;
  logic [31:0]      r_mem_tgt, r_mem_fall;
  logic             r_flush;
  logic [31:0]      r_recover_pc;
  logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;
  logic             r_orphan_err;

  logic             w_resolve;
  logic             w_mis;
  logic             w_orphan;
  logic [CNT_W-1:0] w_cnt_max;

  assign w_resolve = !i_stall && i_mem_branch && r_mem_valid;
  assign w_mis     = w_resolve && (r_mem_pred != i_mem_taken);
  assign w_orphan  = !i_stall && i_mem_branch && !r_mem_valid;
  assign w_cnt_max = '1;

  // A mispredict squashes both the EX entry and the incoming decode branch (wrong path).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_pred   <= 1'b0;
      r_ex_tgt    <= 32'd0;
      r_ex_fall   <= 32'd0;
      r_mem_valid <= 1'b0;
      r_mem_pred  <= 1'b0;
      r_mem_tgt   <= 32'd0;
      r_mem_fall  <= 32'd0;
    end else if (!i_stall) begin
      r_mem_valid <= r_ex_valid && !w_mis;
      r_mem_pred  <= r_ex_pred;
      r_mem_tgt   <= r_ex_tgt;
      r_mem_fall  <= r_ex_fall;
      r_ex_valid  <= i_id_branch && !w_mis;
      r_ex_pred   <= i_id_prediction;
      r_ex_tgt    <= {i_id_target, 2'b00};
      r_ex_fall   <= i_id_pc + 32'd4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flush      <= 1'b0;
      r_recover_pc <= 32'd0;
      r_orphan_err <= 1'b0;
    end else begin
      r_flush <= w_mis;
      if (w_mis)
        r_recover_pc <= i_mem_taken ? r_mem_tgt : r_mem_fall;
      if (w_orphan)
        r_orphan_err <= 1'b1;
    end
  end

  // Counters saturate rather than wrap; clear wins over a same-edge increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (!i_stall) begin
      if (i_cnt_clr) begin
        r_branch_cnt  <= '0;
        r_mispred_cnt <= '0;
      end else begin
        if (w_resolve && r_branch_cnt != w_cnt_max)
          r_branch_cnt <= r_branch_cnt + CNT_W'(1);
        if (w_mis && r_mispred_cnt != w_cnt_max)
          r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign o_flush       = r_flush;
  assign o_recover_pc  = r_recover_pc;
  assign o_branch_cnt  = r_branch_cnt;
  assign o_mispred_cnt = r_mispred_cnt;
  assign o_orphan_err  = r_orphan_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with 4-bit counters so saturation is reachable.
module tb_branch_resolve_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, id_branch, id_prediction, mem_branch, mem_taken, cnt_clr;
  logic [31:0]      id_pc;
  logic [29:0]      id_target;
  logic             flush;
  logic [31:0]      recover_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;
  logic             orphan_err;

  int tests_run = 0;
  int tests_failed = 0;

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_id_branch(id_branch), .i_id_pc(id_pc), .i_id_prediction(id_prediction),
    .i_id_target(id_target), .i_mem_branch(mem_branch), .i_mem_taken(mem_taken),
    .i_cnt_clr(cnt_clr), .o_flush(flush), .o_recover_pc(recover_pc),
    .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt), .o_orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; id_branch = 0; id_prediction = 0; id_pc = 0; id_target = 0;
    mem_branch = 0; mem_taken = 0; cnt_clr = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic pred, input logic [29:0] tgt);
    id_branch = 1; id_pc = pc; id_prediction = pred; id_target = tgt;
    tick();
    id_branch = 0; id_pc = 0; id_prediction = 0; id_target = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    tests_run++;
    if ({flush, recover_pc, branch_cnt, mispred_cnt, orphan_err} !== '0) begin
      $display("FAIL reset: flush=%0b pc=%h b=%0d m=%0d orph=%0b, expected all 0",
               flush, recover_pc, branch_cnt, mispred_cnt, orphan_err);
      tests_failed++;
    end
    rst_n = 1;
    tick();
    tests_run++;
    if (flush !== 1'b0) begin
      $display("FAIL reset_release_flush: got %0b expected 0", flush); tests_failed++;
    end
  endtask

  task automatic test_correct_pred();
    issue(32'h100, 1'b1, 30'h50);
    mem_branch = 1; mem_taken = 1;
    tick();
    mem_branch = 0; mem_taken = 0;
    tests_run++;
    if (flush !== 1'b0) begin
      $display("FAIL correct_flush: got %0b expected 0", flush); tests_failed++;
    end
    tick();
    tests_run++;
    if (flush !== 1'b0 || branch_cnt !== 4'd1 || mispred_cnt !== 4'd0) begin
      $display("FAIL correct_counts: flush=%0b b=%0d m=%0d expected 0/1/0",
               flush, branch_cnt, mispred_cnt);
      tests_failed++;
    end
  endtask

  task automatic test_mispred_taken();
    issue(32'h200, 1'b0, 30'h90);
    mem_branch = 1; mem_taken = 1;
    tick();
    mem_branch = 0; mem_taken = 0;
    tests_run++;
    if (flush !== 1'b1 || recover_pc !== 32'h240) begin
      $display("FAIL mispred_taken_flush: flush=%0b pc=%h expected 1/00000240", flush, recover_pc);
      tests_failed++;
    end
    tests_run++;
    if (branch_cnt !== 4'd2 || mispred_cnt !== 4'd1) begin
      $display("FAIL mispred_taken_counts: b=%0d m=%0d expected 2/1", branch_cnt, mispred_cnt);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (flush !== 1'b0 || recover_pc !== 32'h240) begin
      $display("FAIL mispred_taken_pulse: flush=%0b pc=%h expected 0/00000240", flush, recover_pc);
      tests_failed++;
    end
  endtask

  task automatic test_wrap_and_orphan();
    issue(32'hFFFF_FFFC, 1'b1, 30'h1234);
    mem_branch = 1; mem_taken = 0;
    id_branch = 1; id_pc = 32'h400; id_prediction = 1; id_target = 30'h10;
    tick();
    idle_inputs();
    tests_run++;
    if (flush !== 1'b1 || recover_pc !== 32'h0000_0000) begin
      $display("FAIL wrap_recover: flush=%0b pc=%h expected 1/00000000", flush, recover_pc);
      tests_failed++;
    end
    tick();
    mem_branch = 1; mem_taken = 1;
    tick();
    idle_inputs();
    tests_run++;
    if (orphan_err !== 1'b1 || flush !== 1'b0) begin
      $display("FAIL orphan_set: orph=%0b flush=%0b expected 1/0", orphan_err, flush);
      tests_failed++;
    end
    tests_run++;
    if (branch_cnt !== 4'd3 || mispred_cnt !== 4'd2) begin
      $display("FAIL orphan_counts: b=%0d m=%0d expected 3/2", branch_cnt, mispred_cnt);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (orphan_err !== 1'b1) begin
      $display("FAIL orphan_sticky: got %0b expected 1", orphan_err); tests_failed++;
    end
  endtask

  task automatic test_stall();
    int stall_bad = 0;
    issue(32'h300, 1'b0, 30'hC0);
    mem_branch = 1; mem_taken = 1; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (flush !== 1'b0 || branch_cnt !== 4'd3 || mispred_cnt !== 4'd2) stall_bad++;
    end
    tests_run++;
    if (stall_bad != 0) begin
      $display("FAIL stall_hold: %0d bad cycles, flush=%0b b=%0d m=%0d expected 0/3/2",
               stall_bad, flush, branch_cnt, mispred_cnt);
      tests_failed++;
    end
    stall = 0;
    tick();
    idle_inputs();
    tests_run++;
    if (flush !== 1'b1 || recover_pc !== 32'h300 || branch_cnt !== 4'd4 || mispred_cnt !== 4'd3) begin
      $display("FAIL stall_release: flush=%0b pc=%h b=%0d m=%0d expected 1/00000300/4/3",
               flush, recover_pc, branch_cnt, mispred_cnt);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (flush !== 1'b0 || branch_cnt !== 4'd4) begin
      $display("FAIL stall_single: flush=%0b b=%0d expected 0/4", flush, branch_cnt);
      tests_failed++;
    end
  endtask

  task automatic test_saturation_clear();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    tests_run++;
    if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin
      $display("FAIL clear: b=%0d m=%0d expected 0/0", branch_cnt, mispred_cnt); tests_failed++;
    end
    for (int i = 0; i < 17; i++) begin
      issue(32'h1000 + 32'(i) * 32'h10, 1'b1, 30'h800);
      mem_branch = 1; mem_taken = 0;
      tick();
      mem_branch = 0;
      if (i == 14) begin
        tests_run++;
        if (branch_cnt !== 4'd15 || mispred_cnt !== 4'd15) begin
          $display("FAIL count_15: b=%0d m=%0d expected 15/15", branch_cnt, mispred_cnt);
          tests_failed++;
        end
      end
    end
    tests_run++;
    if (branch_cnt !== 4'd15 || mispred_cnt !== 4'd15) begin
      $display("FAIL saturate: b=%0d m=%0d expected 15/15", branch_cnt, mispred_cnt);
      tests_failed++;
    end
    tests_run++;
    if (recover_pc !== 32'h1104) begin
      $display("FAIL saturate_recover: pc=%h expected 00001104", recover_pc); tests_failed++;
    end
    issue(32'h2000, 1'b1, 30'h900);
    mem_branch = 1; mem_taken = 0; cnt_clr = 1;
    tick();
    idle_inputs();
    tests_run++;
    if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0 || flush !== 1'b1) begin
      $display("FAIL clear_priority: b=%0d m=%0d flush=%0b expected 0/0/1",
               branch_cnt, mispred_cnt, flush);
      tests_failed++;
    end
  endtask

  task automatic test_async_reset();
    issue(32'h500, 1'b1, 30'h200);
    mem_branch = 1; mem_taken = 1;
    tick();
    idle_inputs();
    tests_run++;
    if (branch_cnt !== 4'd1 || orphan_err !== 1'b1) begin
      $display("FAIL pre_reset: b=%0d orph=%0b expected 1/1", branch_cnt, orphan_err);
      tests_failed++;
    end
    id_branch = 1; id_pc = 32'h600; id_prediction = 0; id_target = 30'h300;
    tick();
    idle_inputs();
    #2;
    rst_n = 0;
    #1;
    tests_run++;
    if ({flush, recover_pc, branch_cnt, mispred_cnt, orphan_err} !== '0) begin
      $display("FAIL async_reset: flush=%0b pc=%h b=%0d m=%0d orph=%0b expected all 0",
               flush, recover_pc, branch_cnt, mispred_cnt, orphan_err);
      tests_failed++;
    end
    #1;
    rst_n = 1;
    mem_branch = 1; mem_taken = 1;
    tick();
    idle_inputs();
    tests_run++;
    if (orphan_err !== 1'b1 || flush !== 1'b0 || branch_cnt !== 4'd0) begin
      $display("FAIL post_reset_orphan: orph=%0b flush=%0b b=%0d expected 1/0/0",
               orphan_err, flush, branch_cnt);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (flush !== 1'b0) begin
      $display("FAIL post_reset_flush: got %0b expected 0", flush); tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_correct_pred();
    test_mispred_taken();
    test_wrap_and_orphan();
    test_stall();
    test_saturation_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits directly downstream of the branch predictor FSM.
- Carries each decode-stage prediction, predicted target and fall-through address alongside the pipeline to the MEM stage.
- At MEM, compares the carried prediction with the actual branch decision. On a mismatch it issues a one-cycle flush and the corrected fetch address to the PC-select logic.
- Keeps saturating branch and mispredict counters for performance analysis.

Parameters:
CNT_W, 16, width of the branch_cnt and mispred_cnt performance counters.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  pipeline hold; slots and counters freeze while high.
id_branch  input  1  decode stage holds a branch (branch_decode_sig).
id_pc  input  32  byte address of the decode-stage instruction.
id_prediction  input  1  predictor output: 1 = predicted taken.
id_target  input  30  predicted target word address (branch_addr).
mem_branch  input  1  MEM stage holds a branch (branch_mem_sig).
mem_taken  input  1  actual branch decision in MEM.
cnt_clr  input  1  synchronous clear of both counters.
flush  output  1  one-cycle pulse: squash younger instructions, redirect fetch.
recover_pc  output  32  corrected fetch byte address; valid while flush=1.
branch_cnt  output  CNT_W  resolved branches, saturating.
mispred_cnt  output  CNT_W  mispredicted branches, saturating.
orphan_err  output  1  sticky flag: mem_branch seen with no tracked entry.

Behaviour:
- Reset (rst_n low, asynchronous): both slots invalid; flush=0, recover_pc=0, counters=0, orphan_err=0. Reset asserted mid-flight discards all tracked branches. No flush is issued on deassertion.
- Slot contents. Two slots, EX and MEM. Each slot holds:
  - valid
  - pred
  - tgt = {id_target, 2'b00}
  - fall = id_pc + 4, mod 2^32; id_pc=0xFFFFFFFC wraps to 0x00000000.
- resolve (combinational) = !stall & mem_branch & mem_slot.valid.
- mis (combinational) = resolve & (mem_slot.pred != mem_taken).
- Posedge with stall=0:
  - mem_slot <= ex_slot.
  - ex_slot <= new entry, valid = id_branch & !mis.
  - A mispredict kills the ex_slot contents and the incoming decode branch; both are wrong-path.
- Posedge with stall=1: slots hold. flush is forced to 0; resolution is deferred until stall deasserts.
- flush/recover_pc are registered, so latency is 1 cycle from the resolving edge:
  - flush <= mis.
  - If mis: recover_pc <= mem_taken ? mem_slot.tgt : mem_slot.fall. Otherwise recover_pc holds its previous value.
  - flush is high for exactly one cycle per mispredict.
- Back-to-back branches cannot occur: a branch is always followed by a bubble. The two-slot depth covers ID→EX→MEM.
- A resolved mem_slot entry with resolve=1 is consumed, i.e. it is not re-resolved next cycle. mem_slot.valid is overwritten by the shift, so this holds automatically.
- Orphan error: mem_branch=1 & !stall & !mem_slot.valid sets orphan_err=1. It clears only on reset. No flush and no count in this case.
- Counters, posedge with stall=0:
  - cnt_clr=1 → both counters 0. Clear has priority over any increment on the same edge.
  - Otherwise branch_cnt += resolve and mispred_cnt += mis.
  - Each counter saturates at 2^CNT_W−1; it never wraps.
- Invariant: mispred_cnt ≤ branch_cnt at all times.

Test Plan:
- Correct prediction: id_branch=1, id_pc=0x100, id_prediction=1, id_target=0x50; two cycles later mem_branch=1, mem_taken=1 → flush stays 0, branch_cnt=1, mispred_cnt=0.
- Predicted not-taken, actually taken: id_pc=0x200, id_prediction=0, id_target=0x90; mem_taken=1 → flush=1 for one cycle, one cycle after the resolving edge; recover_pc=0x240; mispred_cnt=1.
- Predicted taken, actually not-taken at id_pc=0xFFFFFFFC → flush=1, recover_pc=0x00000000 (wrap). In the same cycle id_branch=1 on the wrong path → that entry never resolves, and a following mem_branch sets orphan_err=1.
- Stall: assert stall for 3 cycles while the branch sits in the MEM slot with mem_branch=1 → no flush and no count during the stall; a single flush/count follows the first unstalled edge.
- Saturation and clear: with CNT_W=4, resolve 17 mispredicted branches → both counters=15. Then cnt_clr=1 on the same edge as a resolve → both counters=0.
- Async reset: pull rst_n low between the EX and MEM stages of a branch → all outputs 0 immediately without a clock edge; after release, mem_branch=1 → orphan_err=1 and no flush.
